// File: rtl/tnoc_fifo_arbiter_pkg.sv
// Shared types and a reference round-robin select function for the tnoc arbiters.
// Used by tnoc_fifo_arbiter (optional output register: TNOC_FIFO_ARBITER_OUTPUT_REG_EN).
package tnoc_fifo_arbiter_pkg;

  localparam int unsigned TNOC_MAX_REQ = 16;
  localparam int unsigned TNOC_IDX_W   = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } tnoc_arb_state_e;

  typedef struct packed {
    logic                    found;
    logic [TNOC_MAX_REQ-1:0] grant;
    logic [TNOC_IDX_W-1:0]   idx;
  } tnoc_rr_sel_t;

  // First set bit of req at or above ptr, wrapping within the low n bits.
  function automatic tnoc_rr_sel_t rr_select(input logic [TNOC_MAX_REQ-1:0] req,
                                             input logic [TNOC_IDX_W-1:0]   ptr,
                                             input int unsigned             n = TNOC_MAX_REQ);
    tnoc_rr_sel_t r;
    int unsigned  j;
    r = '0;
    for (int unsigned k = 0; k < n; k++) begin
      j = (32'(ptr) + k) % n;
      if (!r.found && req[j]) begin
        r.found    = 1'b1;
        r.idx      = TNOC_IDX_W'(j);
        r.grant[j] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tnoc_fifo_arbiter_rr_select.sv
// Combinational round-robin selector: rotate by ptr, priority-encode, un-rotate.
// Shared by tnoc_fifo_arbiter and later router arbiters.
module tnoc_rr_select
  import tnoc_fifo_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTERS = 2
) (
  input  logic [REQUESTERS-1:0]         req_i,
  input  logic [$clog2(REQUESTERS)-1:0] ptr_i,
  output logic [REQUESTERS-1:0]         grant_o,
  output logic [$clog2(REQUESTERS)-1:0] idx_o,
  output logic                          found_o
);

  localparam int unsigned IW = $clog2(REQUESTERS);

  logic [REQUESTERS-1:0] rot;
  logic [IW-1:0]         off;

  // Operands are always below 2*REQUESTERS, so one conditional subtract wraps.
  function automatic int unsigned wrap(input int unsigned v);
    return (v >= REQUESTERS) ? v - REQUESTERS : v;
  endfunction

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      rot[i] = req_i[wrap(i + 32'(ptr_i))];
    end

    found_o = 1'b0;
    off     = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (!found_o && rot[i]) begin
        found_o = 1'b1;
        off     = IW'(i);
      end
    end

    idx_o   = IW'(wrap(32'(off) + 32'(ptr_i)));
    grant_o = '0;
    if (found_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/tnoc_fifo_arbiter.sv
// Packet-aware round-robin arbiter popping one of REQUESTERS FIFOs onto a valid/ready channel.
// Define TNOC_FIFO_ARBITER_OUTPUT_REG_EN to insert a one-entry registered output stage.
module tnoc_fifo_arbiter
  import tnoc_fifo_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTERS = 2,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_clear,
  input  logic [REQUESTERS-1:0]             i_empty,
  input  logic [REQUESTERS-1:0][WIDTH-1:0]  i_data,
  input  logic [REQUESTERS-1:0]             i_tail,
  output logic [REQUESTERS-1:0]             o_pop,
  output logic [REQUESTERS-1:0]             o_grant,
  output logic                              o_valid,
  output logic [WIDTH-1:0]                  o_data,
  output logic                              o_tail,
  input  logic                              i_ready
);

  localparam int unsigned IW = $clog2(REQUESTERS);

  tnoc_arb_state_e state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   lock_idx_q, lock_idx_d;

  logic [REQUESTERS-1:0] sel_grant;
  logic [IW-1:0]         sel_idx;
  logic                  sel_found;

  logic [IW-1:0] g_idx;
  logic          has_grant;
  logic          head_valid;
  logic          pop_en;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] g);
    return (32'(g) == REQUESTERS - 1) ? '0 : g + IW'(1);
  endfunction

  tnoc_rr_select #(
    .REQUESTERS(REQUESTERS)
  ) u_rr_select (
    .req_i   (~i_empty),
    .ptr_i   (rr_ptr_q),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  // Outputs are combinational, so the asynchronous reset also masks the grant directly.
  always_comb begin
    if (state_q == LOCKED) begin
      g_idx     = lock_idx_q;
      has_grant = !rst;
    end else begin
      g_idx     = sel_idx;
      has_grant = sel_found & !rst;
    end
    o_grant = '0;
    if (has_grant) o_grant = (state_q == LOCKED) ? REQUESTERS'(1) << g_idx : sel_grant;
    head_valid = has_grant & !i_empty[g_idx];
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (i_clear) begin
      state_d    = IDLE;
      rr_ptr_d   = '0;
      lock_idx_d = '0;
    end else if (pop_en) begin
      if (i_tail[g_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = next_idx(g_idx);
      end else begin
        state_d    = LOCKED;
        lock_idx_d = g_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef TNOC_FIFO_ARBITER_OUTPUT_REG_EN
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             tail_q;

  assign pop_en = head_valid & (!valid_q | i_ready) & !i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tail_q  <= 1'b0;
    end else if (i_clear) begin
      valid_q <= 1'b0;
    end else if (pop_en) begin
      valid_q <= 1'b1;
      data_q  <= i_data[g_idx];
      tail_q  <= i_tail[g_idx];
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_tail  = valid_q & tail_q;
`else
  assign pop_en  = head_valid & i_ready & !i_clear;
  assign o_valid = head_valid;
  assign o_data  = i_data[g_idx];
  assign o_tail  = head_valid & i_tail[g_idx];
`endif

  assign o_pop = pop_en ? o_grant : '0;

endmodule

// File: tb/tb_tnoc_fifo_arbiter.sv
// Self-checking bench for tnoc_fifo_arbiter with REQUESTERS=4, WIDTH=8.
module tb_tnoc_fifo_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_clear;
  logic              i_ready;
  logic [N-1:0]      i_empty;
  logic [N-1:0]      i_tail;
  logic [N-1:0][W-1:0] i_data;
  logic [N-1:0]      o_pop;
  logic [N-1:0]      o_grant;
  logic              o_valid;
  logic [W-1:0]      o_data;
  logic              o_tail;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  tnoc_fifo_arbiter #(
    .REQUESTERS(N),
    .WIDTH     (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_clear),
    .i_empty (i_empty),
    .i_data  (i_data),
    .i_tail  (i_tail),
    .o_pop   (o_pop),
    .o_grant (o_grant),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_tail  (o_tail),
    .i_ready (i_ready)
  );

  // Upstream FIFO emulation: {tail, data} per entry.
  logic [W:0]  mem [N][64];
  int unsigned rd  [N];
  int unsigned wr  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned r, input logic [W-1:0] d, input logic t);
    mem[r][wr[r] % 64] = {t, d};
    wr[r]++;
  endtask

  task automatic drive();
    for (int unsigned r = 0; r < N; r++) begin
      i_empty[r] = (rd[r] == wr[r]);
      i_data[r]  = mem[r][rd[r] % 64][W-1:0];
      i_tail[r]  = mem[r][rd[r] % 64][W];
    end
  endtask

`ifdef TNOC_FIFO_ARBITER_OUTPUT_REG_EN
  task automatic adv_dut();
    for (int unsigned r = 0; r < N; r++) if (o_pop[r]) rd[r]++;
    @(posedge clk); #1; drive();
    @(negedge clk); #1;
  endtask
`else
  bit          m_locked = 1'b0;
  int unsigned m_owner  = 0;
  int unsigned m_ptr    = 0;
  int unsigned pop_log[$];
  int unsigned pend[N];
  int unsigned exp_lock[5]  = '{1, 1, 1, 2, 0};
  int unsigned exp_stall[3] = '{2, 2, 3};

  // Reference: locked owner, else first non-empty FIFO from the pointer, wrapping.
  task automatic cycle();
    bit          has;
    bit          ev;
    bit          t;
    int unsigned g;
    logic [N-1:0] eg;
    logic [N-1:0] ep;
    #1;
    has = 1'b0;
    g   = 0;
    if (m_locked) begin
      has = 1'b1;
      g   = m_owner;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!has && rd[(m_ptr + k) % N] != wr[(m_ptr + k) % N]) begin
          has = 1'b1;
          g   = (m_ptr + k) % N;
        end
      end
    end
    ev = has && (rd[g] != wr[g]);
    eg = has ? (N'(1) << g) : '0;
    ep = (ev && i_ready && !i_clear) ? eg : '0;
    chk("grant", o_grant, eg);
    chk("valid", o_valid, ev);
    chk("pop", o_pop, ep);
    if (ev) begin
      chk("data", o_data, mem[g][rd[g] % 64][W-1:0]);
      chk("tail", o_tail, mem[g][rd[g] % 64][W]);
    end
    if (i_clear) begin
      m_locked = 1'b0;
      m_ptr    = 0;
    end else if (ep != '0) begin
      t = mem[g][rd[g] % 64][W];
      pop_log.push_back(g);
      rd[g]++;
      if (t) begin
        m_locked = 1'b0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end
    @(posedge clk); #1; drive();
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int unsigned r = 0; r < N; r++) begin
      rd[r] = 0;
      wr[r] = 0;
      for (int unsigned e = 0; e < 64; e++) mem[r][e] = '0;
    end
    rst     = 1'b1;
    i_clear = 1'b0;
    i_ready = 1'b0;
    for (int unsigned r = 0; r < N; r++) push(r, W'(8'h10 + r), 1'b1);
    drive();

    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_pop", o_pop, 0);
      chk("rst_grant", o_grant, 0);
    end
    @(posedge clk); #1;
    rst     = 1'b0;
    i_ready = 1'b1;
    for (int unsigned r = 0; r < N; r++) push(r, W'(8'h20 + r), 1'b1);
    drive();
    @(negedge clk); #1;
    chk("rel_grant", o_grant, 1);

`ifdef TNOC_FIFO_ARBITER_OUTPUT_REG_EN
    repeat (12) adv_dut();
    chk("drained_valid", o_valid, 0);
    i_ready = 1'b0;
    push(3, 8'hA5, 1'b1);
    drive();
    #1;
    chk("a5_pop", o_pop, 4'b1000);
    chk("a5_valid_pre", o_valid, 0);
    adv_dut();
    chk("a5_valid", o_valid, 1);
    chk("a5_data", o_data, 8'hA5);
    chk("a5_pop_after", o_pop, 0);
    repeat (2) begin
      adv_dut();
      chk("a5_hold_valid", o_valid, 1);
      chk("a5_hold_data", o_data, 8'hA5);
    end
    i_ready = 1'b1;
    #1;
    chk("a5_accept_valid", o_valid, 1);
    adv_dut();
    chk("a5_gone", o_valid, 0);
`else
    // Fair interleave: two single-flit packets per FIFO.
    pop_log.delete();
    repeat (8) cycle();
    chk("fair_cnt", pop_log.size(), 8);
    foreach (pop_log[i]) chk("fair_order", pop_log[i], i % N);

    // Packet lock: pointer moved to 1, then r1 sends 3 flits while r0 and r2 wait.
    push(0, 8'h30, 1'b1);
    drive();
    cycle();
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b0);
    push(1, 8'h43, 1'b1);
    push(0, 8'h31, 1'b1);
    push(2, 8'h50, 1'b1);
    drive();
    pop_log.delete();
    repeat (5) cycle();
    chk("lock_cnt", pop_log.size(), 5);
    foreach (pop_log[i]) if (i < 5) chk("lock_order", pop_log[i], exp_lock[i]);

    // Lock held through a late body flit and a toggling ready.
    push(2, 8'h60, 1'b0);
    push(3, 8'h70, 1'b1);
    drive();
    pop_log.delete();
    for (int unsigned i = 0; i < 10; i++) begin
      if (i == 4) push(2, 8'h61, 1'b1);
      i_ready = (i % 2 == 0);
      drive();
      cycle();
    end
    chk("stall_cnt", pop_log.size(), 3);
    foreach (pop_log[i]) if (i < 3) chk("stall_order", pop_log[i], exp_stall[i]);

    // Clear after the head flit of r2.
    i_ready = 1'b1;
    push(2, 8'h80, 1'b0);
    drive();
    cycle();
    push(2, 8'h81, 1'b0);
    push(2, 8'h82, 1'b1);
    push(0, 8'h90, 1'b1);
    i_clear = 1'b1;
    drive();
    #1;
    chk("clear_no_pop", o_pop, 0);
    cycle();
    i_clear = 1'b0;
    #1;
    chk("clear_r0_wins", o_grant, 1);
    repeat (4) cycle();

    // Randomized traffic: per-requester packets of 1..3 flits trickling in.
    for (int unsigned r = 0; r < N; r++) pend[r] = 0;
    for (int unsigned c = 0; c < 400; c++) begin
      for (int unsigned r = 0; r < N; r++) begin
        if (pend[r] == 0 && (wr[r] - rd[r]) < 8 && $urandom_range(0, 3) == 0)
          pend[r] = $urandom_range(1, 3);
        if (pend[r] != 0 && $urandom_range(0, 2) != 0) begin
          push(r, W'($urandom), pend[r] == 1);
          pend[r]--;
        end
      end
      i_ready = ($urandom_range(0, 3) != 0);
      i_clear = ($urandom_range(0, 39) == 0);
      drive();
      cycle();
    end
    i_clear = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
